game_timer: RTL and testbench

Game-time keeper that produces the `minutes` count consumed by the game-state controller, which uses it for the time-limit loss check at 120, the professor trigger when `minutes[3:0]==15`, quiz deadlines and movement enable. The block divides `Clk` into game seconds and minutes, counts only while the controller reports an active game, saturates instead of wrapping, and clears when the controller returns to its initial state.

---
 rtl/game_pkg.sv | 15 +
 rtl/tick_gen.sv | 27 ++
 rtl/game_timer.sv | 98 +++++++++
 tb/tb_game_timer.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared game constants and the timer state encoding.
// Pure declarations: no logic, no latency, no flow control.
package game_pkg;
    localparam int MAX_TIME    = 120;
    localparam int QUIZ_WINDOW = 10;
    localparam int MINUTES_W   = 8;
    localparam int SECONDS_W   = 6;

    typedef enum logic [1:0] {
        STOP = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        SAT  = 2'd3
    } timer_state_t;
endpackage

// File: rtl/tick_gen.sv
// Modulo-DIV counter that pulses tick on its terminal count, combinationally with en.
// Count holds while en is low; clr zeroes it synchronously and wins over en.
module tick_gen #(
    parameter int DIV = 4,
    parameter int W   = 2
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         en,
    input  logic         clr,
    output logic         tick,
    output logic [W-1:0] cnt
);
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    assign tick = en && (cnt == LAST);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + W'(1);
        end
    end
endmodule

// File: rtl/game_timer.sv
// Game seconds/minutes keeper with run/hold/saturate control; all outputs registered, one-cycle control latency.
// GAME_TIMER_FREEZE_EN makes freeze stall counting like HOLD; otherwise freeze is ignored.
module game_timer
    import game_pkg::*;
#(
    parameter int CLKS_PER_SEC = 100_000_000,
    parameter int SECS_PER_MIN = 60
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 clear,
    input  logic                 run,
    input  logic                 freeze,
    output logic [MINUTES_W-1:0] minutes,
    output logic [SECONDS_W-1:0] seconds,
    output logic                 min_tick,
    output logic                 sat
);
    localparam int PRE_W = $clog2(CLKS_PER_SEC);
    localparam logic [MINUTES_W-1:0] MIN_LAST = {MINUTES_W{1'b1}};

    timer_state_t     state, state_nxt;
    logic             count_en;
    logic             sec_tick;
    logic             min_inc;
    logic             to_sat;
    logic [PRE_W-1:0] unused_pre_cnt;

`ifdef GAME_TIMER_FREEZE_EN
    // Registered so freeze lands one cycle after the input, matching run/HOLD timing.
    logic freeze_q;
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) freeze_q <= 1'b0;
        else       freeze_q <= freeze;
    end
    assign count_en = (state == RUN) && !freeze_q;
`else
    logic unused_freeze;
    assign unused_freeze = freeze;
    assign count_en = (state == RUN);
`endif

    tick_gen #(.DIV(CLKS_PER_SEC), .W(PRE_W)) u_prescale (
        .Clk   (Clk),
        .Reset (Reset),
        .en    (count_en),
        .clr   (clear),
        .tick  (sec_tick),
        .cnt   (unused_pre_cnt)
    );

    tick_gen #(.DIV(SECS_PER_MIN), .W(SECONDS_W)) u_seconds (
        .Clk   (Clk),
        .Reset (Reset),
        .en    (sec_tick),
        .clr   (clear),
        .tick  (min_inc),
        .cnt   (seconds)
    );

    assign to_sat = min_inc && (minutes == MIN_LAST - MINUTES_W'(1));

    always_comb begin
        state_nxt = state;
        case (state)
            STOP: if (run) state_nxt = RUN;
            RUN: begin
                if (to_sat)    state_nxt = SAT;
                else if (!run) state_nxt = HOLD;
            end
            HOLD: if (run) state_nxt = RUN;
            SAT:  state_nxt = SAT;
            default: state_nxt = STOP;
        endcase
        if (clear) state_nxt = STOP;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state <= STOP;
        else       state <= state_nxt;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            minutes  <= '0;
            min_tick <= 1'b0;
            sat      <= 1'b0;
        end else if (clear) begin
            minutes  <= '0;
            min_tick <= 1'b0;
            sat      <= 1'b0;
        end else begin
            min_tick <= min_inc;
            if (min_inc && minutes != MIN_LAST) minutes <= minutes + MINUTES_W'(1);
            if (to_sat) sat <= 1'b1;
        end
    end
endmodule

// File: tb/tb_game_timer.sv
// Directed bench for game_timer with CLKS_PER_SEC=4, SECS_PER_MIN=4 (16 cycles per minute).
module tb_game_timer;
    import game_pkg::*;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       clear = 1'b0;
    logic       run = 1'b0;
    logic       freeze = 1'b0;
    logic [7:0] minutes;
    logic [5:0] seconds;
    logic       min_tick;
    logic       sat;

    int checks = 0;
    int failures = 0;

    game_timer #(.CLKS_PER_SEC(4), .SECS_PER_MIN(4)) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .clear    (clear),
        .run      (run),
        .freeze   (freeze),
        .minutes  (minutes),
        .seconds  (seconds),
        .min_tick (min_tick),
        .sat      (sat)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".minutes"}, 32'(minutes), 0);
        check({tag, ".seconds"}, 32'(seconds), 0);
        check({tag, ".min_tick"}, 32'(min_tick), 0);
        check({tag, ".sat"}, 32'(sat), 0);
    endtask

    task automatic do_clear();
        run = 1'b0;
        clear = 1'b1;
        step(1);
        clear = 1'b0;
    endtask

    initial begin
        // reset state
        #12;
        check_all_zero("reset");
        check("reset.state", 32'(dut.state), 32'(STOP));
        @(negedge Clk);
        Reset = 1'b0;
        step(1);
        check_all_zero("post_reset");

        // first minute: run from cycle 0, minutes=1 at cycle 17
        run = 1'b1;
        step(4);
        check("first.sec0_c4", 32'(seconds), 0);
        step(1);
        check("first.sec1_c5", 32'(seconds), 1);
        step(11);
        check("first.min0_c16", 32'(minutes), 0);
        check("first.sec3_c16", 32'(seconds), 3);
        step(1);
        check("first.min1_c17", 32'(minutes), 1);
        check("first.sec0_c17", 32'(seconds), 0);
        check("first.tick_c17", 32'(min_tick), 1);
        step(1);
        check("first.tick_c18", 32'(min_tick), 0);
        check("first.min1_c18", 32'(minutes), 1);

        // hold: 8 cycles run, 20 cycles stopped, then resume
        do_clear();
        check_all_zero("clear1");
        run = 1'b1;
        step(8);
        run = 1'b0;
        step(1);
        check("hold.sec_c9", 32'(seconds), 2);
        check("hold.state_c9", 32'(dut.state), 32'(HOLD));
        for (int i = 0; i < 19; i++) begin
            step(1);
            check("hold.sec_held", 32'(seconds), 2);
        end
        run = 1'b1;
        step(4);
        check("hold.sec_before", 32'(seconds), 2);
        step(1);
        check("hold.sec_after", 32'(seconds), 3);
        check("hold.min", 32'(minutes), 0);

        // saturation at 255 minutes
        do_clear();
        run = 1'b1;
        step(4080);
        check("sat.min254", 32'(minutes), 254);
        check("sat.sat_low", 32'(sat), 0);
        step(1);
        check("sat.min255", 32'(minutes), 255);
        check("sat.sec0", 32'(seconds), 0);
        check("sat.sat_high", 32'(sat), 1);
        check("sat.tick", 32'(min_tick), 1);
        for (int i = 0; i < 100; i++) begin
            step(1);
            check("sat.min_stay", 32'(minutes), 255);
            check("sat.tick_low", 32'(min_tick), 0);
        end
        check("sat.sec_stay", 32'(seconds), 0);
        check("sat.sat_stay", 32'(sat), 1);

        // clear together with run at minutes=37
        do_clear();
        check_all_zero("clear_sat");
        run = 1'b1;
        step(1 + 37 * 16);
        check("clr.min37", 32'(minutes), 37);
        clear = 1'b1;
        step(1);
        check_all_zero("clr.run");
        check("clr.state", 32'(dut.state), 32'(STOP));
        clear = 1'b0;
        step(16);
        check("clr.min0_c16", 32'(minutes), 0);
        step(1);
        check("clr.min1_c17", 32'(minutes), 1);
        check("clr.tick_c17", 32'(min_tick), 1);

        // freeze for 50 cycles mid-minute
        do_clear();
        run = 1'b1;
        step(23);
        check("frz.min_start", 32'(minutes), 1);
        check("frz.sec_start", 32'(seconds), 1);
        freeze = 1'b1;
        step(50);
        freeze = 1'b0;
`ifdef GAME_TIMER_FREEZE_EN
        check("frz.min_end", 32'(minutes), 1);
        check("frz.sec_end", 32'(seconds), 1);
        check("frz.state", 32'(dut.state), 32'(RUN));
`else
        check("frz.min_end", 32'(minutes), 4);
        check("frz.sec_end", 32'(seconds), 2);
`endif

        // asynchronous Reset at minutes=120
        do_clear();
        run = 1'b1;
        step(1 + 120 * 16);
        check("rst.min120", 32'(minutes), 120);
        #2;
        Reset = 1'b1;
        #1;
        check_all_zero("rst.async");
        run = 1'b0;
        @(negedge Clk);
        Reset = 1'b0;
        step(2);
        check("rst.state", 32'(dut.state), 32'(STOP));
        check_all_zero("rst.after");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
